// File: rtl/hsiao_secded_decoder_pipe_pkg.sv
// Hsiao SECDED code helpers: check-bit count, H-matrix columns and row masks.
package hsiao_pkg;

    // Data columns are odd-weight vectors of at least this weight, so they
    // can never collide with a check-bit column (weight 1) or zero.
    localparam int MIN_COL_WEIGHT = 3;
    localparam int MAX_CHK_W      = 8;

    function automatic int popcnt(input logic [MAX_CHK_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_CHK_W; i++) n += int'(v[i]);
        return n;
    endfunction

    // Smallest r whose odd-weight (>=3) vector count, 2^(r-1) - r, covers data_w.
    function automatic int chk_w(input int data_w);
        int r;
        r = MIN_COL_WEIGHT;
        while (((1 << (r - 1)) - r) < data_w) r++;
        return r;
    endfunction

    // Column k: k-th odd-weight (>=3) vector ordered by weight, then value.
    function automatic logic [MAX_CHK_W-1:0] hcol(input int k, input int cw);
        logic [MAX_CHK_W-1:0] col;
        int n;
        col = '0;
        n   = 0;
        for (int w = MIN_COL_WEIGHT; w <= cw; w += 2) begin
            for (int v = 0; v < (1 << cw); v++) begin
                if (popcnt(8'(v)) == w) begin
                    if (n == k) col = 8'(v);
                    n++;
                end
            end
        end
        return col;
    endfunction

    // Row j of H over the data bits: bit k set when column k has bit j set.
    function automatic logic [63:0] row_mask(input int j, input int data_w, input int cw);
        logic [63:0]          m;
        logic [MAX_CHK_W-1:0] c;
        m = '0;
        for (int k = 0; k < data_w; k++) begin
            c    = hcol(k, cw);
            m[k] = c[j];
        end
        return m;
    endfunction

endpackage

// File: rtl/hsiao_secded_decoder_pipe_syndrome_calc.sv
// Combinational Hsiao syndrome: s[j] = chk[j] ^ parity(data & row j of H).
// With i_chk tied to zero the output is the encoder's check-bit vector.
module hsiao_syndrome_calc
    import hsiao_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [CHK_W-1:0]  i_chk,
    output logic [CHK_W-1:0]  o_syn
);

    for (genvar j = 0; j < CHK_W; j++) begin : g_row
        localparam logic [63:0] MASK = row_mask(j, DATA_W, CHK_W);
        assign o_syn[j] = i_chk[j] ^ (^(i_data & MASK[DATA_W-1:0]));
    end

endmodule

// File: rtl/hsiao_secded_decoder_pipe.sv
// Two-stage Hsiao SECDED decoder with valid/ready flow control and
// saturating sec/ded event counters.
// Optional macro HSIAO_ERR_LOG_EN adds a first-error capture (log_* ports).
module hsiao_secded_decoder_pipe
    import hsiao_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int CHK_W  = chk_w(DATA_W),
    localparam int CODE_W = DATA_W + CHK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic [CHK_W-1:0]  out_syndrome,
    input  logic              cnt_clear,
`ifdef HSIAO_ERR_LOG_EN
    output logic              log_valid,
    output logic [CHK_W-1:0]  log_syndrome,
    output logic              log_ded,
`endif
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);

    // Per-stage valid bits: [1] = S1 (syndrome), [2] = S2 (corrected output).
    logic [2:1]        r_vld_pipe;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_syn;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_sec;
    logic              r_s2_ded;
    logic [CHK_W-1:0]  r_s2_syn;
    logic [CNT_W-1:0]  r_sec_cnt;
    logic [CNT_W-1:0]  r_ded_cnt;

    logic [CHK_W-1:0]  w_syn;
    logic [DATA_W-1:0] w_match;
    logic              w_sec;
    logic              w_ded;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_xfer;

    hsiao_syndrome_calc #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
        .i_data (in_code[DATA_W-1:0]),
        .i_chk  (in_code[CODE_W-1:DATA_W]),
        .o_syn  (w_syn)
    );

    // One-hot match of the registered syndrome against each data column.
    for (genvar k = 0; k < DATA_W; k++) begin : g_col
        localparam logic [MAX_CHK_W-1:0] COL = hcol(k, CHK_W);
        assign w_match[k] = (r_s1_syn == COL[CHK_W-1:0]);
    end

    // Weight-1 syndrome is a check-bit hit: correctable, data untouched.
    assign w_sec = (|w_match) || $onehot(r_s1_syn);
    assign w_ded = (|r_s1_syn) && !w_sec;

    assign w_s2_adv   = !r_vld_pipe[2] || out_ready;
    assign w_s1_adv   = !r_vld_pipe[1] || w_s2_adv;
    assign w_out_xfer = r_vld_pipe[2] && out_ready;

    // S1: capture syndrome and raw data whenever the stage may move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe[1] <= 1'b0;
            r_s1_data     <= '0;
            r_s1_syn      <= '0;
        end else if (w_s1_adv) begin
            r_vld_pipe[1] <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_code[DATA_W-1:0];
                r_s1_syn  <= w_syn;
            end
        end
    end

    // S2: corrected data and flags; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe[2] <= 1'b0;
            r_s2_data     <= '0;
            r_s2_sec      <= 1'b0;
            r_s2_ded      <= 1'b0;
            r_s2_syn      <= '0;
        end else if (w_s2_adv) begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[1]) begin
                r_s2_data <= r_s1_data ^ w_match;
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
                r_s2_syn  <= r_s1_syn;
            end
        end
    end

    // Saturating event counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (cnt_clear) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (w_out_xfer && r_s2_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (w_out_xfer && r_s2_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + 1'b1;
        end
    end

`ifdef HSIAO_ERR_LOG_EN
    logic             r_log_vld;
    logic [CHK_W-1:0] r_log_syn;
    logic             r_log_ded;

    // Capture the first erroneous output word; sticky until cnt_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_log_vld <= 1'b0;
            r_log_syn <= '0;
            r_log_ded <= 1'b0;
        end else if (cnt_clear) begin
            r_log_vld <= 1'b0;
            r_log_syn <= '0;
            r_log_ded <= 1'b0;
        end else if (w_out_xfer && (r_s2_sec || r_s2_ded) && !r_log_vld) begin
            r_log_vld <= 1'b1;
            r_log_syn <= r_s2_syn;
            r_log_ded <= r_s2_ded;
        end
    end

    assign log_valid    = r_log_vld;
    assign log_syndrome = r_log_syn;
    assign log_ded      = r_log_ded;
`endif

    assign in_ready     = w_s1_adv;
    assign out_valid    = r_vld_pipe[2];
    assign out_data     = r_s2_data;
    assign out_sec      = r_s2_sec;
    assign out_ded      = r_s2_ded;
    assign out_syndrome = r_s2_syn;
    assign sec_count    = r_sec_cnt;
    assign ded_count    = r_ded_cnt;

endmodule

// File: tb/tb_hsiao_secded_decoder_pipe.sv
// Directed bench for hsiao_secded_decoder_pipe (DATA_W=32, CHK_W=7).
// A narrow counter width keeps the saturation scenario short.
module tb_hsiao_secded_decoder_pipe;

    localparam int DW    = 32;
    localparam int CW    = 7;
    localparam int CDW   = DW + CW;
    localparam int CNT_W = 8;
    localparam int SATV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic             cnt_clear = 1'b0;
    logic [CDW-1:0]   in_code = '0;
    logic             in_ready, out_valid, out_sec, out_ded;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_syndrome;
    logic [CNT_W-1:0] sec_count, ded_count;
`ifdef HSIAO_ERR_LOG_EN
    logic             log_valid, log_ded;
    logic [CW-1:0]    log_syndrome;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int exp_sec = 0;
    int exp_ded = 0;

    always #5 clk = ~clk;

    hsiao_secded_decoder_pipe #(.DATA_W(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .out_syndrome (out_syndrome),
        .cnt_clear    (cnt_clear),
`ifdef HSIAO_ERR_LOG_EN
        .log_valid    (log_valid),
        .log_syndrome (log_syndrome),
        .log_ded      (log_ded),
`endif
        .sec_count    (sec_count),
        .ded_count    (ded_count)
    );

    // Column k of H for 7 check bits: odd weight >= 3, by weight then value.
    function automatic logic [CW-1:0] tcol(input int k);
        int n;
        n = 0;
        for (int w = 3; w <= CW; w += 2)
            for (int v = 1; v < (1 << CW); v++)
                if ($countones(v) == w) begin
                    if (n == k) return 7'(v);
                    n++;
                end
        return '0;
    endfunction

    function automatic logic [CDW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < DW; k++) if (d[k]) c ^= tcol(k);
        return {c, d};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, out_sec, out_ded, out_data, out_syndrome} !== '0)
            $display("FAIL reset_outputs: got v=%b d=%h syn=%h want all zero", out_valid, out_data, out_syndrome);
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_chk++;
        if ({sec_count, ded_count} !== '0) $display("FAIL reset_counters: got %0d/%0d want 0/0", sec_count, ded_count);
        else n_pass++;
    endtask

    task automatic test_clean_stream();
        logic [DW-1:0] d;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            in_valid = (c < 100);
            in_code  = enc(32'hDEADBEEF + 32'(c));
            #1;
            n_chk++;
            if (c >= 2) begin
                d = 32'hDEADBEEF + 32'(c - 2);
                if ({out_valid, out_data, out_sec, out_ded, in_ready} !== {1'b1, d, 1'b0, 1'b0, 1'b1})
                    $display("FAIL clean_word%0d: got v=%b d=%h sec=%b ded=%b rdy=%b want v=1 d=%h sec=0 ded=0 rdy=1",
                             c - 2, out_valid, out_data, out_sec, out_ded, in_ready, d);
                else n_pass++;
            end else begin
                if (out_valid !== 1'b0) $display("FAIL clean_latency%0d: got out_valid=%b want 0", c, out_valid);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({out_valid, sec_count, ded_count} !== {1'b0, CNT_W'(0), CNT_W'(0)})
            $display("FAIL clean_drain: got v=%b sec=%0d ded=%0d want 0/0/0", out_valid, sec_count, ded_count);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [CDW-1:0] flip [8];
        logic [CW-1:0]  syn  [8];
        logic [7:0]     sec, ded;
        logic [DW-1:0]  d;
        flip = '{39'h1, 39'h1 << 35, 39'h1 << 31, 39'h1 << 38,
                 39'h3, 39'h1F << 32, 39'h70 << 32, 39'h0};
        syn  = '{7'h07, 7'h08, 7'h62, 7'h40, 7'h0C, 7'h1F, 7'h70, 7'h00};
        sec  = 8'b0000_1111;
        ded  = 8'b0111_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d        = 32'h12345678 + 32'(i * 32'h1111);
            in_valid = 1'b1;
            in_code  = enc(d) ^ flip[i];
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            n_chk++;
            if ({out_valid, out_syndrome, out_sec, out_ded} !== {1'b1, syn[i], sec[i], ded[i]})
                $display("FAIL single%0d_flags: got v=%b syn=%h sec=%b ded=%b want v=1 syn=%h sec=%b ded=%b",
                         i, out_valid, out_syndrome, out_sec, out_ded, syn[i], sec[i], ded[i]);
            else n_pass++;
            if (!ded[i]) begin
                n_chk++;
                if (out_data !== d) $display("FAIL single%0d_data: got %h want %h", i, out_data, d);
                else n_pass++;
            end
            exp_sec += int'(sec[i]);
            exp_ded += int'(ded[i]);
            @(negedge clk);
            #1;
            n_chk++;
            if ({sec_count, ded_count} !== {CNT_W'(exp_sec), CNT_W'(exp_ded)})
                $display("FAIL single%0d_counts: got %0d/%0d want %0d/%0d", i, sec_count, ded_count, exp_sec, exp_ded);
            else n_pass++;
`ifdef HSIAO_ERR_LOG_EN
            n_chk++;
            if ({log_valid, log_syndrome, log_ded} !== {1'b1, 7'h07, 1'b0})
                $display("FAIL single%0d_log: got v=%b syn=%h ded=%b want 1/07/0", i, log_valid, log_syndrome, log_ded);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_stall_random();
        logic [DW-1:0]  dat  [64];
        logic [CDW-1:0] code [64];
        logic [DW+CW+1:0] saved;
        logic held;
        int tx, rx, cyc;
        tx = 0; rx = 0; cyc = 0; held = 1'b0; saved = '0;
        for (int i = 0; i < 64; i++) begin
            dat[i]  = (32'(i) * 32'h01010101) ^ 32'hC3C30000;
            code[i] = enc(dat[i]);
            if (i % 2 == 1) code[i] ^= (39'h1 << ((i * 7) % CDW));
        end
        while ((rx < 64) && (cyc < 3000)) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (tx < 64);
            if (tx < 64) in_code = code[tx];
            #1;
            if (held) begin
                n_chk++;
                if (!out_valid || ({out_data, out_sec, out_ded, out_syndrome} !== saved))
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid,
                             {out_data, out_sec, out_ded, out_syndrome}, saved);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if ({out_data, out_sec, out_ded} !== {dat[rx], 1'(rx % 2), 1'b0})
                    $display("FAIL stall_word%0d: got d=%h sec=%b ded=%b want d=%h sec=%0d ded=0",
                             rx, out_data, out_sec, out_ded, dat[rx], rx % 2);
                else n_pass++;
                rx++;
            end
            held  = out_valid && !out_ready;
            saved = {out_data, out_sec, out_ded, out_syndrome};
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        n_chk++;
        if (rx != 64) $display("FAIL stall_count: got %0d words want 64", rx);
        else n_pass++;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        exp_sec += 32;
        n_chk++;
        if ({out_valid, sec_count, ded_count} !== {1'b0, CNT_W'(exp_sec), CNT_W'(exp_ded)})
            $display("FAIL stall_tail: got v=%b sec=%0d ded=%0d want v=0 sec=%0d ded=%0d",
                     out_valid, sec_count, ded_count, exp_sec, exp_ded);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int n;
        n = SATV - exp_sec + 2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_code  = enc(32'(i) * 32'h9E3779B9) ^ 39'h1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp_sec = SATV;
        n_chk++;
        if ({sec_count, ded_count} !== {CNT_W'(SATV), CNT_W'(exp_ded)})
            $display("FAIL saturate: got %0d/%0d want %0d/%0d", sec_count, ded_count, SATV, exp_ded);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = enc(32'h55AA55AA) ^ (39'h1 << 36);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (sec_count !== CNT_W'(SATV)) $display("FAIL saturate_hold: got %0d want %0d", sec_count, SATV);
        else n_pass++;
    endtask

    task automatic test_clear();
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = enc(32'h0F0F0F0F) ^ (39'h1 << 5);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cnt_clear = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, out_sec} !== 2'b11) $display("FAIL clear_setup: got v=%b sec=%b want 1/1", out_valid, out_sec);
        else n_pass++;
        @(negedge clk);
        cnt_clear = 1'b0;
        #1;
        exp_sec = 0;
        exp_ded = 0;
        n_chk++;
        if ({sec_count, ded_count} !== '0) $display("FAIL clear_priority: got %0d/%0d want 0/0", sec_count, ded_count);
        else n_pass++;
`ifdef HSIAO_ERR_LOG_EN
        n_chk++;
        if (log_valid !== 1'b0) $display("FAIL clear_log: got log_valid=%b want 0", log_valid);
        else n_pass++;
`endif
        in_valid = 1'b1;
        in_code  = enc(32'hF0F0F0F0) ^ 39'h3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp_ded = 1;
        n_chk++;
        if ({sec_count, ded_count} !== {CNT_W'(0), CNT_W'(1)})
            $display("FAIL clear_recount: got %0d/%0d want 0/1", sec_count, ded_count);
        else n_pass++;
`ifdef HSIAO_ERR_LOG_EN
        n_chk++;
        if ({log_valid, log_syndrome, log_ded} !== {1'b1, 7'h0C, 1'b1})
            $display("FAIL clear_log_capture: got v=%b syn=%h ded=%b want 1/0c/1", log_valid, log_syndrome, log_ded);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = enc(32'h11111111) ^ 39'h1;
        @(negedge clk);
        in_code  = enc(32'h22222222) ^ 39'h2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b1) $display("FAIL inflight_setup: got out_valid=%b want 1", out_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, in_ready, sec_count, ded_count} !== {1'b0, 1'b1, CNT_W'(0), CNT_W'(0)})
            $display("FAIL inflight_reset: got v=%b rdy=%b cnt=%0d/%0d want 0/1/0/0", out_valid, in_ready, sec_count, ded_count);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL inflight_discard: got out_valid=%b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = enc(32'hCAFEF00D) ^ (39'h1 << 31);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_latency: got out_valid=%b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if ({out_valid, out_data, out_sec, out_ded, out_syndrome} !== {1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 7'h62})
            $display("FAIL post_reset_word: got v=%b d=%h sec=%b ded=%b syn=%h want 1 cafef00d 1 0 62",
                     out_valid, out_data, out_sec, out_ded, out_syndrome);
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if ({sec_count, ded_count} !== {CNT_W'(1), CNT_W'(0)})
            $display("FAIL post_reset_counts: got %0d/%0d want 1/0", sec_count, ded_count);
        else n_pass++;
`ifdef HSIAO_ERR_LOG_EN
        n_chk++;
        if ({log_valid, log_syndrome, log_ded} !== {1'b1, 7'h62, 1'b0})
            $display("FAIL post_reset_log: got v=%b syn=%h ded=%b want 1/62/0", log_valid, log_syndrome, log_ded);
        else n_pass++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_stream();
        test_single();
        test_stall_random();
        test_saturate();
        test_clear();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hsiao_secded_decoder_pipe.md
Name: hsiao_secded_decoder_pipe

Overview:
- Parametrised, pipelined Hsiao SECDED decoder for memory read paths. It generalises the team's fixed 8-bit decoder in three ways: arbitrary data width, true Hsiao odd-weight-column code with no separate overall-parity bit, and valid/ready streaming.
- Adds saturating error-event counters for the memory-health monitor.
- Sits between the SRAM read port and the requesting master.

Parameters:
- DATA_W, 32, data bits per word (4..64).
- CHK_W, derived (package function), check bits. Smallest r with (count of odd-weight r-bit vectors of weight ≥3) ≥ DATA_W, e.g. 32→7, 8→5, 64→8.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept a word.
- in_code  in  DATA_W+CHK_W  codeword; [DATA_W-1:0] data, [DATA_W+CHK_W-1:DATA_W] check bits.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  corrected data.
- out_sec  out  1  single error corrected (data or check bit).
- out_ded  out  1  uncorrectable error detected.
- out_syndrome  out  CHK_W  raw syndrome of the word.
- cnt_clear  in  1  synchronous clear of both counters.
- sec_count  out  CNT_W  saturating count of corrected words.
- ded_count  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Code matrix H:
  - Data column k is the k-th entry of the list of odd-weight ≥3 CHK_W-bit vectors, sorted by weight, then ascending value. For CHK_W=7: col0=0x07, col1=0x0B, col2=0x0D.
  - Check bit j has column 1<<j.
- Syndrome s[j] = check bit j XOR (XOR of data bits whose column has bit j set).
- Classification:
  - s==0 → clean.
  - s matches a data column → flip that data bit, sec=1.
  - s has weight 1 → check-bit error; data unchanged, sec=1.
  - s nonzero, even weight → ded=1.
  - s odd weight with no matching column → ded=1 (multi-bit).
  - sec and ded are never both 1.
- Pipeline (2 stages):
  - S1 registers the syndrome plus a copy of the data.
  - S2 registers the corrected data, flags, and syndrome.
  - Latency: 2 cycles from accepted input to out_valid when not stalled.
- Handshake:
  - A transfer happens when valid && ready.
  - Each stage advances when it is empty or the next stage advances.
  - in_ready = S1 empty OR S1 advancing.
  - Full throughput: 1 word/cycle with out_ready held high.
  - out_* outputs hold stable while out_valid && !out_ready.
  - Words are never dropped or duplicated.
- Counters:
  - Increment once per output transfer (out_valid && out_ready) with sec or ded set.
  - Saturate at 2^CNT_W-1.
  - cnt_clear has priority over a same-cycle increment; the result is 0.
- Reset (async assert, sync-safe deassert):
  - Pipeline emptied.
  - out_valid=0, out_data=0, out_sec=0, out_ded=0, out_syndrome=0.
  - Counters 0.
  - in_ready=1 after reset.
  - Words in flight at reset are discarded.

Optional Feature:
- Macro HSIAO_ERR_LOG_EN.
- When defined, add outputs:
  - log_valid (1)
  - log_syndrome (CHK_W)
  - log_ded (1)
- On the first output transfer with sec or ded after reset or cnt_clear, these capture that word's syndrome and ded flag, and log_valid goes to 1.
- Later errors do not overwrite the capture until cnt_clear.
- When undefined, the ports and logic are absent.

Decomposition:
- Package hsiao_pkg holds:
  - function chk_w(data_w)
  - function hcol(k, chk_w), which returns column k
  - localparam-style helpers for column weight
- One sub-module, hsiao_syndrome_calc: combinational syndrome generation from H. The encoder reuses it.
- Correction, pipeline and counters stay in the top module.

Test Plan:
- DATA_W=32, data 0xDEADBEEF with correct checks, 100 words back-to-back, out_ready=1 → outputs match inputs at 2-cycle latency, sec=ded=0, counters 0.
- Flip data bit 0 → syndrome 0x07, out_data restored, sec=1, sec_count=1. Flip check bit 3 → syndrome 0x08, data unchanged, sec=1.
- Flip data bits 0 and 1 → syndrome 0x0C (even weight), ded=1, sec=0, ded_count increments.
- out_ready toggling at random (50%) with a stream of 64 words, half of them with single-bit errors → no loss or duplication, outputs stable while stalled, sec_count=32.
- Force sec_count to 0xFFFF via errors, inject one more → stays 0xFFFF. Assert cnt_clear in the same cycle as an error → 0.
- Assert rst_n low with 2 words in flight → out_valid=0 immediately, counters 0, first post-reset word decoded correctly. With HSIAO_ERR_LOG_EN: log captures the first error only.
